fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 104 ++++++++++
 tb/tb_fifo_burst_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Pulls fixed-size bursts out of an upstream FIFO: a full BURST_LEN burst once enough data
// is queued, or a short burst of whatever is present after TIMEOUT idle cycles.
module fifo_burst_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 256,
  parameter int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  parameter int BURST_LEN     = 16,
  parameter int TIMEOUT       = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LB_FIFO_DEPTH:0]         in_count,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [$clog2(BURST_LEN+1)-1:0] out_len
);
  localparam int LW = $clog2(BURST_LEN+1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = LB_FIFO_DEPTH + 1;
  localparam logic [CW-1:0] BL_C  = CW'(BURST_LEN);
  localparam logic [LW-1:0] BL_L  = LW'(BURST_LEN);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT-1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] beat_cnt, len;
  logic [TW-1:0] timer;
  logic          abort, cnt_nz, start_full, start_short, last, beat;

  assign abort       = rst | clear;
  assign cnt_nz      = (in_count != '0);
  assign start_full  = (state == IDLE) && (in_count >= BL_C);
  // full-burst rule wins when both could fire
  assign start_short = (state == IDLE) && cnt_nz && !start_full && (timer == T_MAX);
  assign last        = (state == BURST) && (beat_cnt == len - 1'b1);
  assign beat        = (state == BURST) && in_valid && out_ready && !abort;

  always_ff @(posedge clk) begin
    if (abort) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_full || start_short) state_nxt = BURST;
      BURST:   if (beat && last)              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      beat_cnt <= '0;
      len      <= '0;
      timer    <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
      if (start_full) begin
        len   <= BL_L;
        timer <= '0;
      end else if (start_short) begin
        len   <= LW'(in_count);
        timer <= '0;
      end else if (cnt_nz) begin
        timer <= (timer == T_MAX) ? timer : timer + 1'b1;
      end else begin
        timer <= '0;
      end
    end else begin
      timer <= '0;
      if (beat) begin
        if (last) begin
          beat_cnt <= '0;
          len      <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // pure pass-through handshake while bursting; everything quiet while reset/clear is high
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_len   = '0;
    out_data  = in_data;
    if (state == BURST && !abort) begin
      in_ready  = out_ready;
      out_valid = in_valid;
      out_last  = last;
      out_len   = len;
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed + random stimulus for fifo_burst_reader, checked cycle by cycle against a
// burst-level model of the start/length/beat rules.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int BL = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [8:0]    in_count;
  logic          in_ready, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [4:0]    out_len;

  fifo_burst_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(256), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_count(in_count), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_len(out_len)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // model: are we in a burst, its length, beats delivered, consecutive idle cycles with data waiting
  bit m_burst;
  int m_len, m_beats, m_idle;
  // scenario statistics observed on the DUT ports
  int nbeats, nlast, first_v, cyc, gap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    nbeats = 0; nlast = 0; first_v = -1; cyc = 0;
  endtask

  task automatic step();
    bit rs, act;
    int ic;
    rs  = rst | clear;
    act = m_burst && !rs;
    #1;
    chk("out_valid", out_valid, act ? in_valid : 1'b0);
    chk("in_ready",  in_ready,  act ? out_ready : 1'b0);
    chk("out_last",  out_last,  act && (m_beats == m_len - 1));
    chk("out_len",   out_len,   act ? m_len : 0);
    if (out_valid) chk("out_data", out_data, in_data);
    if (out_valid && out_ready) begin
      nbeats++;
      if (out_last) nlast++;
    end
    if (out_valid && first_v < 0) first_v = cyc;
    @(posedge clk);
    ic = in_count;
    if (rs) begin
      m_burst = 0; m_len = 0; m_beats = 0; m_idle = 0;
    end else if (!m_burst) begin
      if (ic >= BL) begin
        m_burst = 1; m_len = BL; m_beats = 0; m_idle = 0;
      end else if (ic > 0 && m_idle >= TO - 1) begin
        m_burst = 1; m_len = ic; m_beats = 0; m_idle = 0;
      end else if (ic > 0) m_idle++;
      else m_idle = 0;
    end else if (in_valid && out_ready) begin
      if (m_beats == m_len - 1) begin
        m_burst = 0; m_len = 0; m_beats = 0;
      end else m_beats++;
    end
    cyc++;
    #1;
    in_data = DW'($urandom);
  endtask

  initial begin
    rst = 1; clear = 0; in_valid = 0; out_ready = 0; in_count = 0; in_data = 0;
    m_burst = 0; m_len = 0; m_beats = 0; m_idle = 0;
    clr_stats();
    step(); step();
    rst = 0; in_valid = 1; out_ready = 1;
    step();

    // full burst
    clr_stats(); in_count = 20;
    for (int i = 0; i < 40 && nlast == 0; i++) step();
    chk("full_beats", nbeats, 16);
    chk("full_last", nlast, 1);
    chk("full_latency", first_v, 1);
    in_count = 0; step();

    // timeout short burst
    clr_stats(); in_count = 3;
    for (int i = 0; i < 120 && nlast == 0; i++) step();
    chk("timeout_first_valid", first_v, 64);
    chk("timeout_beats", nbeats, 3);
    in_count = 0; step();

    // backpressure
    clr_stats(); in_count = 20;
    for (int i = 0; i < 80 && nlast == 0; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    chk("bp_beats", nbeats, 16);
    chk("bp_last", nlast, 1);
    out_ready = 1; in_count = 0; step();

    // starved input after beat 5
    clr_stats(); in_count = 16; gap = 0;
    for (int i = 0; i < 80 && nlast == 0; i++) begin
      if (nbeats == 5 && gap < 10) begin
        in_valid = 0; gap++;
      end else in_valid = 1;
      step();
    end
    chk("starve_gap", gap, 10);
    chk("starve_beats", nbeats, 16);
    in_valid = 1; in_count = 0; step();

    // abort after beat 7, then a fresh burst
    clr_stats(); in_count = 16;
    for (int i = 0; i < 40 && nbeats < 7; i++) step();
    clear = 1; step(); clear = 0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_len", out_len, 0);
    chk("abort_nolast", nlast, 0);
    for (int i = 0; i < 40 && nlast == 0; i++) step();
    chk("abort_total_beats", nbeats, 23);
    in_count = 0; step();

    // timer restart after in_count drops to zero
    in_count = 2;
    repeat (40) step();
    in_count = 0; step();
    clr_stats(); in_count = 2;
    for (int i = 0; i < 120 && nlast == 0; i++) step();
    chk("timer_restart_first_valid", first_v, 64);
    chk("timer_restart_beats", nbeats, 2);
    in_count = 0; step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 80 == 0)
        in_count = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(16, 40)) : 9'($urandom_range(0, 5));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 299) == 0);
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end
    rst = 0; clear = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
